operand_issue: RTL and testbench

Operand-issue front end for `top_cpu`. Buffers encoded instructions, reads source operands from a 16×16 architectural register file, and drives the ALU/writeback core inputs `f0`, `opcode_rd`, `rs1`, `rs2`, `cin` and `bin` under a valid/ready handshake. It is the reader side of the core's writeback path: results return on the `wb_*` port, update the register file and clear the destination scoreboard bit.

---
 rtl/operand_issue_if.sv | 31 +++
 rtl/operand_issue.sv | 97 +++++++++
 tb/tb_operand_issue.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/operand_issue_if.sv
// operand_issue_if: instruction, issue, writeback and status bundle for operand_issue
interface operand_issue_if #(
    parameter int DW = 16,
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    logic [15:0] instr_in;
    logic instr_valid;
    logic instr_ready;
    logic [1:0] f0;
    logic [3:0] opcode_rd;
    logic [DW-1:0] rs1;
    logic [DW-1:0] rs2;
    logic cin;
    logic bin;
    logic issue_valid;
    logic issue_ready;
    logic wb_en;
    logic [3:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic [15:0] pending;
    logic [CW-1:0] fifo_count;
    modport master (
        output instr_in, instr_valid, issue_ready, wb_en, wb_addr, wb_data,
        input instr_ready, f0, opcode_rd, rs1, rs2, cin, bin, issue_valid, pending, fifo_count
    );
    modport slave (
        input instr_in, instr_valid, issue_ready, wb_en, wb_addr, wb_data,
        output instr_ready, f0, opcode_rd, rs1, rs2, cin, bin, issue_valid, pending, fifo_count
    );
endinterface

// File: rtl/operand_issue.sv
// operand_issue: instruction FIFO, scoreboarded operand read and issue register (optional OPERAND_ISSUE_BYPASS_EN writeback forwarding)
module operand_issue #(
    parameter int FIFO_DEPTH = 4,
    parameter int DW = 16
) (
    input logic clk,
    input logic rst,
    operand_issue_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    typedef enum logic [1:0] {EMPTY, VALID, STALLED} state_t;
    state_t state, state_nx;
    logic [15:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [DW-1:0] rf [16];
    logic [15:0] pending, wb_mask, set_mask, src_pend, head;
    logic [3:0] h_rd, h_rs1, h_rs2;
    logic head_valid, hazard, push, pop, retire, occupied;
    logic [DW-1:0] op1, op2;
    logic [1:0] iss_f0;
    logic [3:0] iss_rd;
    logic [DW-1:0] iss_rs1, iss_rs2;
    logic iss_cin, iss_bin;
    assign head = mem[rd_ptr];
    assign h_rd = head[13:10];
    assign h_rs1 = head[9:6];
    assign h_rs2 = head[5:2];
    assign head_valid = count != '0;
    assign wb_mask = bus.wb_en ? 16'(1) << bus.wb_addr : '0;
`ifdef OPERAND_ISSUE_BYPASS_EN
    // only source hazards are released early; the destination check keeps the registered scoreboard
    assign src_pend = pending & ~wb_mask;
    assign op1 = (bus.wb_en && bus.wb_addr == h_rs1) ? bus.wb_data : rf[h_rs1];
    assign op2 = (bus.wb_en && bus.wb_addr == h_rs2) ? bus.wb_data : rf[h_rs2];
`else
    assign src_pend = pending;
    assign op1 = rf[h_rs1];
    assign op2 = rf[h_rs2];
`endif
    assign hazard = src_pend[h_rs1] | src_pend[h_rs2] | pending[h_rd];
    assign occupied = state != EMPTY;
    assign retire = occupied && bus.issue_ready;
    assign pop = head_valid && !hazard && (!occupied || bus.issue_ready);
    assign push = bus.instr_valid && bus.instr_ready;
    assign set_mask = pop ? 16'(1) << h_rd : '0;
    always_comb begin
        state_nx = pop ? VALID : (state == EMPTY || retire) ? EMPTY : (head_valid && hazard) ? STALLED : VALID;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else state <= state_nx;
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.instr_in;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            pending <= '0;
            iss_f0 <= '0;
            iss_rd <= '0;
            iss_rs1 <= '0;
            iss_rs2 <= '0;
            iss_cin <= 1'b0;
            iss_bin <= 1'b0;
            for (int i = 0; i < 16; i++) rf[i] <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
            pending <= (pending & ~wb_mask) | set_mask;
            if (bus.wb_en) rf[bus.wb_addr] <= bus.wb_data;
            if (pop) begin
                iss_f0 <= head[15:14];
                iss_rd <= h_rd;
                iss_rs1 <= op1;
                iss_rs2 <= op2;
                iss_cin <= head[1];
                iss_bin <= head[0];
            end
        end
    end
    assign bus.instr_ready = count != CW'(FIFO_DEPTH);
    assign bus.fifo_count = count;
    assign bus.pending = pending;
    assign bus.issue_valid = occupied;
    assign bus.f0 = iss_f0;
    assign bus.opcode_rd = iss_rd;
    assign bus.rs1 = iss_rs1;
    assign bus.rs2 = iss_rs2;
    assign bus.cin = iss_cin;
    assign bus.bin = iss_bin;
endmodule

// File: tb/tb_operand_issue.sv
// tb_operand_issue: table vectors plus hand sequences, issued instructions checked against an expected queue
module tb_operand_issue;
`ifdef OPERAND_ISSUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    typedef struct packed {
        logic [1:0] f0;
        logic [3:0] rd;
        logic [15:0] a;
        logic [15:0] b;
        logic cin;
        logic bin;
    } exp_t;
    typedef struct {
        logic [15:0] instr;
        exp_t exp;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int passed = 0;
    exp_t exp_q[$];
    logic [15:0] mrf [16];
    vec_t tbl [10];
    operand_issue_if #(.DW(16), .FIFO_DEPTH(4)) bus ();
    operand_issue #(.FIFO_DEPTH(4), .DW(16)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    function automatic logic [15:0] mk(input logic [1:0] f0, input logic [3:0] rd, input logic [3:0] s1,
                                       input logic [3:0] s2, input logic c, input logic b);
        return {f0, rd, s1, s2, c, b};
    endfunction
    function automatic logic [15:0] iv(input int idx);
        return 16'h1000 + 16'(idx) * 16'h0011;
    endfunction
    function automatic exp_t mexp(input logic [1:0] f0, input logic [3:0] rd, input logic [3:0] s1,
                                  input logic [3:0] s2, input logic c, input logic b);
        return '{f0, rd, mrf[s1], mrf[s2], c, b};
    endfunction
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wb_write(input logic [3:0] a, input logic [15:0] d);
        bus.wb_en = 1'b1;
        bus.wb_addr = a;
        bus.wb_data = d;
        tick();
        bus.wb_en = 1'b0;
        mrf[a] = d;
    endtask
    task automatic init_rf();
        for (int i = 0; i < 16; i++) wb_write(4'(i), iv(i));
    endtask
    task automatic send(input logic [15:0] w);
        bit ok = 1'b0;
        bus.instr_in = w;
        bus.instr_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            ok = bus.instr_ready;
            tick();
        end
        bus.instr_valid = 1'b0;
        if (!ok) begin
            total++;
            $display("FAIL send_timeout: instr %h not accepted within 50 cycles", w);
        end
    endtask
    always @(negedge clk) begin
        if (!rst && bus.issue_valid && bus.issue_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL retire_unexpected: got rd %0d rs1 %h with nothing expected", bus.opcode_rd, bus.rs1);
            end else begin
                check("retire", {bus.f0, bus.opcode_rd, bus.rs1, bus.rs2, bus.cin, bus.bin}, exp_q.pop_front());
            end
        end
    end
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        for (int i = 0; i < 10; i++) begin
            tbl[i].instr = mk(2'(i % 4), 4'(6 + i), 4'(i % 6), 4'((i + 2) % 6), i[0], i[1]);
            tbl[i].exp = '{2'(i % 4), 4'(6 + i), iv(i % 6), iv((i + 2) % 6), i[0], i[1]};
        end
        for (int i = 0; i < 16; i++) mrf[i] = '0;
        bus.instr_in = '0;
        bus.instr_valid = 1'b0;
        bus.issue_ready = 1'b0;
        bus.wb_en = 1'b0;
        bus.wb_addr = '0;
        bus.wb_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_issue_valid", bus.issue_valid, 0);
        check("rst_instr_ready", bus.instr_ready, 1);
        check("rst_pending", bus.pending, 0);
        check("rst_fifo_count", bus.fifo_count, 0);
        check("rst_outputs", {bus.f0, bus.opcode_rd, bus.rs1, bus.rs2, bus.cin, bus.bin}, 0);
        rst = 1'b0;
        tick();
        // basic issue
        wb_write(1, 16'd120);
        wb_write(2, 16'd10);
        bus.issue_ready = 1'b1;
        exp_q.push_back(mexp(2'd0, 4'd3, 4'd1, 4'd2, 1'b0, 1'b0));
        send(mk(2'd0, 4'd3, 4'd1, 4'd2, 1'b0, 1'b0));
        bus.issue_ready = 1'b0;
        check("basic_not_yet", bus.issue_valid, 0);
        tick();
        check("basic_valid", bus.issue_valid, 1);
        check("basic_rs1", bus.rs1, 120);
        check("basic_rs2", bus.rs2, 10);
        check("basic_rd", bus.opcode_rd, 3);
        check("basic_f0", bus.f0, 0);
        check("basic_pending", bus.pending, 16'h0008);
        // RAW stall behind a held instruction
        exp_q.push_back('{2'd0, 4'd4, 16'd130, 16'd10, 1'b0, 1'b0});
        send(mk(2'd0, 4'd4, 4'd3, 4'd2, 1'b0, 1'b0));
        tick();
        check("raw_held_valid", bus.issue_valid, 1);
        check("raw_held_rd", bus.opcode_rd, 3);
        check("raw_buffered", bus.fifo_count, 1);
        bus.issue_ready = 1'b1;
        tick();
        bus.issue_ready = 1'b0;
        check("raw_drop_valid", bus.issue_valid, 0);
        check("raw_still_buffered", bus.fifo_count, 1);
        wb_write(3, 16'd130);
        check("raw_release_valid", bus.issue_valid, BYP ? 1 : 0);
        check("raw_release_pending", bus.pending, BYP ? 16'h0010 : 16'h0000);
        tick();
        check("raw_issue_valid", bus.issue_valid, 1);
        check("raw_issue_rs1", bus.rs1, 130);
        check("raw_issue_rs2", bus.rs2, 10);
        check("raw_issue_pending", bus.pending, 16'h0010);
        bus.issue_ready = 1'b1;
        tick();
        init_rf();
        check("clear_pending", bus.pending, 0);
        // backpressure and full buffer
        bus.issue_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(mexp(2'(i % 4), 4'(8 + i), 4'(i), 4'(i + 1), i[0], 1'b1));
            send(mk(2'(i % 4), 4'(8 + i), 4'(i), 4'(i + 1), i[0], 1'b1));
        end
        check("full_count", bus.fifo_count, 4);
        check("full_ready", bus.instr_ready, 0);
        check("full_issue_valid", bus.issue_valid, 1);
        check("full_issue_rd", bus.opcode_rd, 8);
        bus.issue_ready = 1'b1;
        repeat (6) tick();
        check("drain_count", bus.fifo_count, 0);
        check("drain_valid", bus.issue_valid, 0);
        check("drain_pending", bus.pending, 16'h1F00);
        // wrap-around stream at full rate
        init_rf();
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(tbl[i].exp);
            send(tbl[i].instr);
        end
        repeat (2) tick();
        check("stream_drained", bus.issue_valid, 0);
        check("stream_queue", exp_q.size(), 0);
        check("stream_pending", bus.pending, 16'hFFC0);
        // WAW, then stray writeback colliding with issue
        init_rf();
        exp_q.push_back(mexp(2'd1, 4'd5, 4'd0, 4'd1, 1'b0, 1'b0));
        send(mk(2'd1, 4'd5, 4'd0, 4'd1, 1'b0, 1'b0));
        exp_q.push_back(mexp(2'd2, 4'd5, 4'd2, 4'd3, 1'b1, 1'b1));
        send(mk(2'd2, 4'd5, 4'd2, 4'd3, 1'b1, 1'b1));
        repeat (2) tick();
        check("waw_wait_count", bus.fifo_count, 1);
        check("waw_wait_valid", bus.issue_valid, 0);
        check("waw_wait_pending", bus.pending, 16'h0020);
        wb_write(5, 16'h5555);
        check("waw_extra_cycle", bus.issue_valid, 0);
        check("waw_cleared", bus.pending, 0);
        tick();
        check("waw_issue_valid", bus.issue_valid, 1);
        check("waw_issue_rd", bus.opcode_rd, 5);
        check("waw_issue_pending", bus.pending, 16'h0020);
        exp_q.push_back(mexp(2'd3, 4'd7, 4'd0, 4'd1, 1'b0, 1'b1));
        send(mk(2'd3, 4'd7, 4'd0, 4'd1, 1'b0, 1'b1));
        bus.wb_en = 1'b1;
        bus.wb_addr = 4'd7;
        bus.wb_data = 16'h7777;
        tick();
        bus.wb_en = 1'b0;
        mrf[7] = 16'h7777;
        check("collide_pending", bus.pending, 16'h00A0);
        tick();
        // reset mid-operation
        bus.issue_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(mk(2'd0, 4'(8 + i), 4'd0, 4'd1, 1'b0, 1'b0));
        check("pre_rst_count", bus.fifo_count, 3);
        check("pre_rst_pending", bus.pending, 16'h01A0);
        #2;
        rst = 1'b1;
        #1;
        exp_q.delete();
        for (int i = 0; i < 16; i++) mrf[i] = '0;
        check("mid_rst_valid", bus.issue_valid, 0);
        check("mid_rst_ready", bus.instr_ready, 1);
        check("mid_rst_count", bus.fifo_count, 0);
        check("mid_rst_pending", bus.pending, 0);
        check("mid_rst_outputs", {bus.f0, bus.opcode_rd, bus.rs1, bus.rs2, bus.cin, bus.bin}, 0);
        tick();
        rst = 1'b0;
        tick();
        bus.issue_ready = 1'b1;
        wb_write(1, 16'h0BEE);
        exp_q.push_back(mexp(2'd2, 4'd8, 4'd1, 4'd2, 1'b1, 1'b0));
        send(mk(2'd2, 4'd8, 4'd1, 4'd2, 1'b1, 1'b0));
        tick();
        check("post_rst_valid", bus.issue_valid, 1);
        check("post_rst_rs1", bus.rs1, 16'h0BEE);
        check("post_rst_pending", bus.pending, 16'h0100);
        repeat (2) tick();
        check("final_queue", exp_q.size(), 0);
        check("final_valid", bus.issue_valid, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
